// File: rtl/button_event_decoder_pkg.sv
// Shared types and default timing constants for the button event decoder.
package button_event_decoder_pkg;

  // Defaults for the top-level configuration, in ticks.
  localparam int DEF_LONG_TICKS = 50;
  localparam int DEF_GAP_TICKS  = 25;

  // Decoder FSM states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_WAIT2     = 3'd2,
    ST_PRESS2    = 3'd3,
    ST_LONG_HELD = 3'd4
  } state_e;

endpackage

// File: rtl/button_event_decoder.sv
// Classifies debounced button activity into short / double / long events.
// All outputs are registered; pulses are one tick wide and mutually exclusive.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int LONG_TICKS = DEF_LONG_TICKS,
  parameter int GAP_TICKS  = DEF_GAP_TICKS,
  parameter int TMR_W      = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk_tick,
  input  logic             rst,
  input  logic             btn_i,
  output logic             short_o,
  output logic             double_o,
  output logic             long_o,
  output logic             hold_o,
  output logic [CNT_W-1:0] event_cnt_o
);

  // The long threshold is hit one tick early because the tick that sampled
  // the press edge already counts as a pressed tick.
  localparam logic [TMR_W-1:0] LONG_HIT = TMR_W'(LONG_TICKS - 2);
  localparam logic [TMR_W-1:0] GAP_HIT  = TMR_W'(GAP_TICKS - 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               btn_q;
  logic               short_q, short_d;
  logic               double_q, double_d;
  logic               long_q, long_d;
  logic               hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rise;
  logic               any_evt;

  assign rise    = btn_i & ~btn_q;
  assign any_evt = short_d | double_d | long_d;

  // Next-state, pulse and timer logic; release always beats the long threshold.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    hold_d   = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (!btn_i) begin
          state_d = ST_WAIT2;
        end else if (timer_q == LONG_HIT) begin
          long_d  = 1'b1;
          hold_d  = 1'b1;
          state_d = ST_LONG_HELD;
        end
      end
      ST_WAIT2: begin
        if (btn_i) begin
          state_d = ST_PRESS2;
        end else if (timer_q == GAP_HIT) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        if (!btn_i) begin
          double_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (timer_q == LONG_HIT) begin
          long_d  = 1'b1;
          hold_d  = 1'b1;
          state_d = ST_LONG_HELD;
        end
      end
      ST_LONG_HELD: begin
        if (!btn_i) begin
          hold_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        hold_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q == ST_PRESS1 || state_q == ST_WAIT2 ||
                 state_q == ST_PRESS2) begin
      timer_d = timer_q + 1'b1;
    end

    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, any_evt};
  end

  // State and output registers; btn_q resets high so a button held through
  // reset is ignored until it is first seen released.
  always_ff @(posedge clk_tick or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      btn_q    <= 1'b1;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      hold_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      btn_q    <= btn_i;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
    end
  end

  assign short_o     = short_q;
  assign double_o    = double_q;
  assign long_o      = long_q;
  assign hold_o      = hold_q;
  assign event_cnt_o = cnt_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Randomized and directed bench for button_event_decoder. The reference
// model derives the expected event timeline from run lengths of the input
// level sequence.
module tb_button_event_decoder;

  localparam int LONG = 10;
  localparam int GAP  = 4;
  localparam int CW   = 8;
  localparam int MAXN = 4096;

  logic          clk_tick = 1'b0;
  logic          rst      = 1'b1;
  logic          btn_i    = 1'b0;
  logic          short_o, double_o, long_o, hold_o;
  logic [CW-1:0] event_cnt_o;

  button_event_decoder #(
    .LONG_TICKS(LONG), .GAP_TICKS(GAP), .TMR_W(8), .CNT_W(CW)
  ) dut (
    .clk_tick(clk_tick), .rst(rst), .btn_i(btn_i),
    .short_o(short_o), .double_o(double_o), .long_o(long_o),
    .hold_o(hold_o), .event_cnt_o(event_cnt_o)
  );

  always #5 clk_tick = ~clk_tick;

  int n_chk = 0;
  int n_err = 0;

  bit stim [MAXN];
  bit e_s  [MAXN];
  bit e_d  [MAXN];
  bit e_l  [MAXN];
  bit e_h  [MAXN];
  int n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input bit lvl, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      if (n < MAXN) begin
        stim[n] = lvl;
        n++;
      end
    end
  endtask

  function automatic int runlen(input int s);
    int l = 0;
    while (s + l < n && stim[s + l]) l++;
    return l;
  endfunction

  task automatic mark_long(input int e, input int len);
    if (e + LONG - 1 < n) e_l[e + LONG - 1] = 1'b1;
    for (int k = e + LONG - 1; k <= e + len - 1; k++)
      if (k < n) e_h[k] = 1'b1;
  endtask

  // Walk the level sequence press by press, placing each event at the index
  // of the input tick whose sampling edge produces it.
  task automatic build_model();
    int  i, e, len, r, p, len2;
    bit  prev;
    for (int k = 0; k < n; k++) begin
      e_s[k] = 0; e_d[k] = 0; e_l[k] = 0; e_h[k] = 0;
    end
    i = 0;
    prev = 1'b1;
    while (i < n) begin
      if (!(stim[i] && !prev)) begin
        prev = stim[i];
        i++;
        continue;
      end
      e   = i;
      len = runlen(e);
      if (len >= LONG) begin
        mark_long(e, len);
        i = e + len + 1;
        prev = 1'b0;
        continue;
      end
      r = e + len;
      p = -1;
      for (int k = r + 1; k <= r + GAP; k++)
        if (p < 0 && k < n && stim[k]) p = k;
      if (p < 0) begin
        if (r + GAP < n) e_s[r + GAP] = 1'b1;
        i = r + GAP + 1;
      end else begin
        len2 = runlen(p);
        if (len2 >= LONG) mark_long(p, len2);
        else if (p + len2 < n) e_d[p + len2] = 1'b1;
        i = p + len2 + 1;
      end
      prev = 1'b0;
    end
  endtask

  task automatic do_reset(input bit lvl);
    rst   = 1'b1;
    btn_i = lvl;
    repeat (2) @(posedge clk_tick);
    #1;
    chk("rst_short",  short_o,     0);
    chk("rst_double", double_o,    0);
    chk("rst_long",   long_o,      0);
    chk("rst_hold",   hold_o,      0);
    chk("rst_cnt",    event_cnt_o, 0);
    @(negedge clk_tick);
    rst = 1'b0;
  endtask

  // Reset, then play stim[0..n-1] one level per tick against the model.
  task automatic run_seq(input string name, input int final_cnt);
    int cnt;
    build_model();
    do_reset(stim[0]);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_tick);
      btn_i = stim[i];
      @(posedge clk_tick);
      #1;
      if (e_s[i] || e_d[i] || e_l[i]) cnt++;
      chk({name, ".short"},  short_o,  e_s[i]);
      chk({name, ".double"}, double_o, e_d[i]);
      chk({name, ".long"},   long_o,   e_l[i]);
      chk({name, ".hold"},   hold_o,   e_h[i]);
      chk({name, ".cnt"},    event_cnt_o, cnt % (1 << CW));
    end
    if (final_cnt >= 0) chk({name, ".final_cnt"}, event_cnt_o, final_cnt);
  endtask

  initial begin
    // 1: short press
    n = 0; push(0, 2); push(1, 3); push(0, 10);
    run_seq("t1_short", 1);
    // 2: double click
    n = 0; push(0, 2); push(1, 2); push(0, 2); push(1, 2); push(0, 10);
    run_seq("t2_double", 1);
    // 3: long press with hold
    n = 0; push(0, 2); push(1, 15); push(0, 10);
    run_seq("t3_long", 1);
    // 4: held through reset, then a normal short press
    n = 0; push(1, 20); push(0, 3); push(1, 2); push(0, 10);
    run_seq("t4_heldrst", 1);
    // 5: second press lands on the gap timeout tick
    n = 0; push(0, 2); push(1, 3); push(0, GAP); push(1, 2); push(0, 10);
    run_seq("t5_gapedge", 1);
    // release on exactly the long threshold tick
    n = 0; push(0, 2); push(1, LONG - 1); push(0, 10);
    run_seq("tx_relwin", 1);
    // 6: short then long second press: long only
    n = 0; push(0, 2); push(1, 2); push(0, 1); push(1, 12); push(0, 10);
    run_seq("t6_long2", 1);

    // 6b: asynchronous reset while a long press is held
    @(negedge clk_tick); btn_i = 1'b1;
    repeat (LONG + 2) @(negedge clk_tick);
    chk("t6_pre_hold", hold_o, 1);
    chk("t6_pre_cnt",  event_cnt_o, 2);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_hold",  hold_o,      0);
    chk("t6_async_cnt",   event_cnt_o, 0);
    chk("t6_async_pulse", {short_o, double_o, long_o}, 0);
    btn_i = 1'b0;

    // randomized level sequences
    for (int s = 0; s < 3; s++) begin
      n = 0;
      push(0, 3);
      while (n < 2400) begin
        push(1, $urandom_range(1, LONG + 4));
        push(0, $urandom_range(1, GAP + 3));
      end
      push(0, 20);
      run_seq("rand", -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the debounced button level produced by the debouncer stage. Runs in the same clk_tick domain.
- Classifies each button interaction as a short press, a double click or a long press.
- Emits one-tick event pulses, a held-level flag and a wrapping event counter for downstream control logic (mode select, PLL config stepping).

Parameters:
- LONG_TICKS, default 50: consecutive pressed ticks that make a press long. Legal range 2..2^TMR_W-1.
- GAP_TICKS, default 25: released ticks after a first release within which a second press counts as a double click. Legal range 2..2^TMR_W-1.
- TMR_W, default 8: width of the internal tick timer.
- CNT_W, default 8: width of event_cnt_o.

Ports:
- clk_tick  in   1      block clock: one-cycle-wide tick domain shared with the debouncer.
- rst       in   1      reset: asynchronous, active-high.
- btn_i     in   1      debounced button level; 1 = pressed. Already synchronous to clk_tick.
- short_o   out  1      one-tick pulse: single short press completed.
- double_o  out  1      one-tick pulse: two short presses within GAP_TICKS completed.
- long_o    out  1      one-tick pulse: press reached LONG_TICKS.
- hold_o    out  1      level: 1 from the long_o tick until release is sampled.
- event_cnt_o out CNT_W count of emitted events, wraps modulo 2^CNT_W.

Behaviour:
- All outputs are registered.
- Reset values:
  - short_o, double_o, long_o, hold_o = 0.
  - event_cnt_o = 0, timer = 0, state = IDLE.
  - btn_q = 1, so a button held through reset release is ignored until it is first seen released.
- Rising edge definition: btn_i=1 while btn_q=0. btn_q <= btn_i every tick.
- State machine (timer clears on every state change; otherwise increments each tick while in PRESS1, WAIT2 or PRESS2):
  - IDLE: on rising edge -> PRESS1.
  - PRESS1:
    - btn_i=0 -> WAIT2.
    - Else, if timer==LONG_TICKS-2 -> pulse long_o, set hold_o, go to LONG_HELD. The press tick plus LONG_TICKS-1 further ticks give LONG_TICKS pressed ticks in total.
  - WAIT2:
    - btn_i=1 -> PRESS2.
    - Else, if timer==GAP_TICKS-1 -> pulse short_o, go to IDLE.
  - PRESS2:
    - btn_i=0 -> pulse double_o, go to IDLE.
    - Else, if timer==LONG_TICKS-2 -> pulse long_o, set hold_o, go to LONG_HELD. The first press is discarded; no short_o or double_o is emitted.
  - LONG_HELD: btn_i=0 -> clear hold_o, go to IDLE. No further pulses while held.
- Pulses are exactly one tick wide. At most one of short_o, double_o, long_o is high in any tick.
- event_cnt_o increments by 1 in the same tick any pulse is asserted and wraps from all-ones to 0.
- Latency:
  - short_o goes high GAP_TICKS ticks after the tick in which the release was sampled.
  - double_o goes high the tick after the second release is sampled.
- Boundary cases:
  - A press arriving in the same tick WAIT2 times out is a new press: go to PRESS2, no short_o.
  - A release in the same tick the long threshold is hit counts as a release: the release wins.
  - A press during LONG_HELD is impossible; a re-press after release starts fresh in IDLE.
  - Reset asserted mid-sequence aborts without emitting any pulse.
  - The timer never wraps, because the thresholds are below 2^TMR_W.

Decomposition:
- Shared package holds:
  - the state enum: IDLE, PRESS1, WAIT2, PRESS2, LONG_HELD, encoded in 3 bits;
  - the default LONG_TICKS and GAP_TICKS constants, shared with the top-level configuration.
- No sub-module. A single FSM with its timer is natural, and the edge register is inline.

Test Plan (LONG_TICKS=10, GAP_TICKS=4):
1. Press 3 ticks, release, hold released 6 ticks -> short_o high for 1 tick, 4 ticks after release sampled; event_cnt_o=1; double_o and long_o stay 0.
2. Press 2, release 2, press 2, release -> double_o high 1 tick, one tick after second release; no short_o; event_cnt_o=1.
3. Press held 15 ticks -> long_o pulses on the 10th pressed tick; hold_o high from then until the tick after release; event_cnt_o=1.
4. btn_i=1 during and after reset release for 20 ticks, then released -> no pulses, state stays IDLE. The next press is then recognised normally.
5. Press 3, release, press in the exact tick WAIT2 times out (timer==3) -> no short_o; the second release gives double_o.
6. Press 2, release, press 12 -> long_o only; short_o and double_o stay 0. Assert rst mid-press on a repeat -> all outputs 0 immediately (asynchronously), event_cnt_o=0.
